decode_mod: RTL and testbench

- Instruction-decode (ID) stage of the 5-stage RV64I pipeline; sits between the fetch stage and the execute stage.
- Contains the 32x64 integer register file.
- Captures the fetched instruction and its next-PC, splits out the fields, and reads the source-register values.
- Presents a registered ID/EX bundle to execute, one cycle after capture.

---
 rtl/decode_mod.sv | 215 +++++++++++++++++++++
 tb/tb_decode_mod.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/decode_mod.sv
// RV64I instruction-decode stage: 32x64 register file, field extraction and a
// registered ID/EX bundle presented to execute one cycle after capture.
module decode_mod #(
  parameter int unsigned NREGS = 32,
  parameter int unsigned XLEN  = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] stackptr,
  input  logic [31:0]     IFID_instreg,
  input  logic [XLEN-1:0] IFID_npc,
  input  logic            IFID_ready,
  input  logic            wb_we,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            IDEX_ready,
  output logic [XLEN-1:0] IDEX_npc,
  output logic [63:0]     opcode,
  output logic [XLEN-1:0] rs1,
  output logic [XLEN-1:0] rs2,
  output logic [5:0]      rd,
  output logic [19:0]     immediate,
  output logic [5:0]      IDEX_rs1reg,
  output logic [5:0]      IDEX_rs2reg
);

  localparam int unsigned IDX_W = 5;
  localparam int unsigned REG_W = 6;
  localparam int unsigned IMM_W = 20;
  localparam int unsigned OPC_W = 64;
  localparam int unsigned SP_IDX = 2;

  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_IMM32  = 7'h1B;
  localparam logic [6:0] OP_OP     = 7'h33;
  localparam logic [6:0] OP_OP32   = 7'h3B;

  typedef struct packed {
    logic             ready;
    logic [XLEN-1:0]  npc;
    logic [OPC_W-1:0] opcode;
    logic [XLEN-1:0]  rs1;
    logic [XLEN-1:0]  rs2;
    logic [REG_W-1:0] rd;
    logic [IMM_W-1:0] imm;
    logic [REG_W-1:0] rs1reg;
    logic [REG_W-1:0] rs2reg;
  } idex_t;

  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];

  idex_t idex_q;
  idex_t idex_d;

  logic [6:0]       op;
  logic [2:0]       f3;
  logic [6:0]       f7;
  logic             known;
  logic             use_rd;
  logic             use_rs1;
  logic             use_rs2;
  logic             use_f3;
  logic             use_f7;
  logic [IMM_W-1:0] imm_val;
  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W-1:0] rs1_idx;
  logic [IDX_W-1:0] rs2_idx;
  logic [XLEN-1:0]  rs1_val;
  logic [XLEN-1:0]  rs2_val;

  // Format classification: which fields this major opcode actually uses.
  always_comb begin
    op      = IFID_instreg[6:0];
    known   = 1'b1;
    use_rd  = 1'b0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    use_f3  = 1'b0;
    use_f7  = 1'b0;
    imm_val = '0;
    case (op)
      OP_LUI, OP_AUIPC: begin
        use_rd  = 1'b1;
        imm_val = IFID_instreg[31:12];
      end
      OP_JAL: begin
        use_rd  = 1'b1;
        imm_val = {IFID_instreg[31], IFID_instreg[19:12], IFID_instreg[20],
                   IFID_instreg[30:21]};
      end
      OP_JALR, OP_LOAD, OP_IMM, OP_IMM32: begin
        use_rd  = 1'b1;
        use_rs1 = 1'b1;
        use_f3  = 1'b1;
        use_f7  = ((op == OP_IMM) || (op == OP_IMM32)) &&
                  (IFID_instreg[13:12] == 2'b01);
        imm_val = {{8{IFID_instreg[31]}}, IFID_instreg[31:20]};
      end
      OP_STORE: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        use_f3  = 1'b1;
        imm_val = {{8{IFID_instreg[31]}}, IFID_instreg[31:25], IFID_instreg[11:7]};
      end
      OP_BRANCH: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        use_f3  = 1'b1;
        imm_val = {{7{IFID_instreg[31]}}, IFID_instreg[31], IFID_instreg[7],
                   IFID_instreg[30:25], IFID_instreg[11:8], 1'b0};
      end
      OP_OP, OP_OP32: begin
        use_rd  = 1'b1;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        use_f3  = 1'b1;
        use_f7  = 1'b1;
      end
      default: known = 1'b0;
    endcase
  end

  // Unused fields collapse to zero so unused operands read x0.
  always_comb begin
    f3      = use_f3  ? IFID_instreg[14:12] : 3'd0;
    f7      = use_f7  ? IFID_instreg[31:25] : 7'd0;
    rd_idx  = use_rd  ? IFID_instreg[11:7]  : '0;
    rs1_idx = use_rs1 ? IFID_instreg[19:15] : '0;
    rs2_idx = use_rs2 ? IFID_instreg[24:20] : '0;
  end

  // Register read with write-through bypass from the same-cycle writeback.
  always_comb begin
    rs1_val = '0;
    if (rs1_idx != '0) begin
      if (wb_we && (wb_rd == rs1_idx)) rs1_val = wb_data;
      else                             rs1_val = regs_q[rs1_idx];
    end
  end

  always_comb begin
    rs2_val = '0;
    if (rs2_idx != '0) begin
      if (wb_we && (wb_rd == rs2_idx)) rs2_val = wb_data;
      else                             rs2_val = regs_q[rs2_idx];
    end
  end

  always_comb begin
    regs_d = regs_q;
    if (wb_we && (wb_rd != '0)) regs_d[wb_rd] = wb_data;
  end

  // x2 tracks stackptr for as long as reset is held.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs_q[i] <= (i == SP_IDX) ? stackptr : '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Next ID/EX bundle; an unrecognised opcode becomes a bubble that keeps npc.
  always_comb begin
    idex_d       = idex_q;
    idex_d.ready = 1'b0;
    if (IFID_ready) begin
      idex_d.ready = 1'b1;
      idex_d.npc   = IFID_npc;
      if (known) begin
        idex_d.opcode = OPC_W'({f7, f3, op});
        idex_d.rs1    = rs1_val;
        idex_d.rs2    = rs2_val;
        idex_d.rd     = REG_W'(rd_idx);
        idex_d.imm    = imm_val;
        idex_d.rs1reg = REG_W'(rs1_idx);
        idex_d.rs2reg = REG_W'(rs2_idx);
      end else begin
        idex_d.opcode = '0;
        idex_d.rs1    = '0;
        idex_d.rs2    = '0;
        idex_d.rd     = '0;
        idex_d.imm    = '0;
        idex_d.rs1reg = '0;
        idex_d.rs2reg = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) idex_q <= '0;
    else        idex_q <= idex_d;
  end

  assign IDEX_ready  = idex_q.ready;
  assign IDEX_npc    = idex_q.npc;
  assign opcode      = idex_q.opcode;
  assign rs1         = idex_q.rs1;
  assign rs2         = idex_q.rs2;
  assign rd          = idex_q.rd;
  assign immediate   = idex_q.imm;
  assign IDEX_rs1reg = idex_q.rs1reg;
  assign IDEX_rs2reg = idex_q.rs2reg;

endmodule

// File: tb/tb_decode_mod.sv
// Directed bench for decode_mod: hand-computed ID/EX bundles per instruction.
module tb_decode_mod;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] stackptr;
  logic [31:0] IFID_instreg;
  logic [63:0] IFID_npc;
  logic        IFID_ready;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;
  logic        IDEX_ready;
  logic [63:0] IDEX_npc;
  logic [63:0] opcode;
  logic [63:0] rs1;
  logic [63:0] rs2;
  logic [5:0]  rd;
  logic [19:0] immediate;
  logic [5:0]  IDEX_rs1reg;
  logic [5:0]  IDEX_rs2reg;

  int checks = 0;
  int errors = 0;

  decode_mod dut (
    .clk          (clk),
    .reset        (reset),
    .stackptr     (stackptr),
    .IFID_instreg (IFID_instreg),
    .IFID_npc     (IFID_npc),
    .IFID_ready   (IFID_ready),
    .wb_we        (wb_we),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .IDEX_ready   (IDEX_ready),
    .IDEX_npc     (IDEX_npc),
    .opcode       (opcode),
    .rs1          (rs1),
    .rs2          (rs2),
    .rd           (rd),
    .immediate    (immediate),
    .IDEX_rs1reg  (IDEX_rs1reg),
    .IDEX_rs2reg  (IDEX_rs2reg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_bundle(input string tag, input logic rdy, input logic [63:0] npc,
                               input logic [63:0] opc, input logic [5:0] rdv,
                               input logic [19:0] imm, input logic [5:0] r1reg,
                               input logic [5:0] r2reg, input logic [63:0] r1v,
                               input logic [63:0] r2v);
    chk({tag, ".ready"},  64'(IDEX_ready),  64'(rdy));
    chk({tag, ".npc"},    IDEX_npc,         npc);
    chk({tag, ".opcode"}, opcode,           opc);
    chk({tag, ".rd"},     64'(rd),          64'(rdv));
    chk({tag, ".imm"},    64'(immediate),   64'(imm));
    chk({tag, ".rs1reg"}, 64'(IDEX_rs1reg), 64'(r1reg));
    chk({tag, ".rs2reg"}, 64'(IDEX_rs2reg), 64'(r2reg));
    chk({tag, ".rs1"},    rs1,              r1v);
    chk({tag, ".rs2"},    rs2,              r2v);
  endtask

  task automatic step(input logic [31:0] inst, input logic [63:0] npc, input logic rdy,
                      input logic we, input logic [4:0] wrd, input logic [63:0] wdat);
    @(negedge clk);
    IFID_instreg = inst;
    IFID_npc     = npc;
    IFID_ready   = rdy;
    wb_we        = we;
    wb_rd        = wrd;
    wb_data      = wdat;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset        = 1'b0;
    stackptr     = 64'h7FF0;
    IFID_instreg = 32'h0;
    IFID_npc     = 64'h0;
    IFID_ready   = 1'b0;
    wb_we        = 1'b0;
    wb_rd        = 5'd0;
    wb_data      = 64'h0;
    repeat (3) @(posedge clk);
    #1;
    expect_bundle("reset", 1'b0, 64'h0, 64'h0, 6'd0, 20'h0, 6'd0, 6'd0, 64'h0, 64'h0);
    @(negedge clk);
    reset = 1'b1;

    // add x2,x2,x0: x2 holds stackptr
    step(32'h00010133, 64'h1000, 1'b1, 1'b0, 5'd0, 64'h0);
    expect_bundle("add", 1'b1, 64'h1000, 64'h33, 6'd2, 20'h0, 6'd2, 6'd0, 64'h7FF0, 64'h0);

    // addi x5,x0,-1: funct7 bits must not leak into opcode
    step(32'hFFF00293, 64'h1004, 1'b1, 1'b0, 5'd0, 64'h0);
    expect_bundle("addi", 1'b1, 64'h1004, 64'h13, 6'd5, 20'hFFFFF, 6'd0, 6'd0, 64'h0, 64'h0);

    // sub x3,x1,x2 with same-cycle write of x1 -> bypass
    step(32'h402081B3, 64'h1008, 1'b1, 1'b1, 5'd1, 64'h1234);
    expect_bundle("sub_byp", 1'b1, 64'h1008, 64'h8033, 6'd3, 20'h0, 6'd1, 6'd2, 64'h1234, 64'h7FF0);

    // sd x2,8(x1): x1 now read from the register file
    step(32'h0020B423, 64'h100C, 1'b1, 1'b0, 5'd0, 64'h0);
    expect_bundle("sd", 1'b1, 64'h100C, 64'h1A3, 6'd0, 20'h00008, 6'd1, 6'd2, 64'h1234, 64'h7FF0);

    // beq x1,x2,-4
    step(32'hFE208EE3, 64'h1010, 1'b1, 1'b0, 5'd0, 64'h0);
    expect_bundle("beq", 1'b1, 64'h1010, 64'h63, 6'd0, 20'hFFFFC, 6'd1, 6'd2, 64'h1234, 64'h7FF0);

    // lui x7,0x12345
    step(32'h123453B7, 64'h1014, 1'b1, 1'b0, 5'd0, 64'h0);
    expect_bundle("lui", 1'b1, 64'h1014, 64'h37, 6'd7, 20'h12345, 6'd0, 6'd0, 64'h0, 64'h0);

    // IFID_ready low: only IDEX_ready drops
    step(32'h00010133, 64'h1018, 1'b0, 1'b0, 5'd0, 64'h0);
    expect_bundle("hold", 1'b0, 64'h1014, 64'h37, 6'd7, 20'h12345, 6'd0, 6'd0, 64'h0, 64'h0);

    // add x4,x0,x0 while writing 0xFFFF to x0: no bypass, no write
    step(32'h00000233, 64'h1018, 1'b1, 1'b1, 5'd0, 64'hFFFF);
    expect_bundle("x0_wr", 1'b1, 64'h1018, 64'h33, 6'd4, 20'h0, 6'd0, 6'd0, 64'h0, 64'h0);
    step(32'h00000233, 64'h101C, 1'b1, 1'b0, 5'd0, 64'h0);
    expect_bundle("x0_rd", 1'b1, 64'h101C, 64'h33, 6'd4, 20'h0, 6'd0, 6'd0, 64'h0, 64'h0);

    // Unrecognised opcode 0x7F -> bubble keeping npc
    step(32'hFFFFFFFF, 64'h2000, 1'b1, 1'b0, 5'd0, 64'h0);
    expect_bundle("bubble", 1'b1, 64'h2000, 64'h0, 6'd0, 20'h0, 6'd0, 6'd0, 64'h0, 64'h0);

    // jal x1,+0x1000 (inst[14:12]=001 is offset, funct3 forced 0); write x6
    step(32'h000010EF, 64'h2004, 1'b1, 1'b1, 5'd6, 64'hABCD);
    expect_bundle("jal", 1'b1, 64'h2004, 64'h6F, 6'd1, 20'h00800, 6'd0, 6'd0, 64'h0, 64'h0);

    // srai x6,x6,3: shift-immediate keeps funct7
    step(32'h40335313, 64'h2008, 1'b1, 1'b0, 5'd0, 64'h0);
    expect_bundle("srai", 1'b1, 64'h2008, 64'h8293, 6'd6, 20'h00403, 6'd6, 6'd0, 64'hABCD, 64'h0);

    // Mid-operation asynchronous reset clears the bundle immediately
    @(negedge clk);
    reset = 1'b0;
    #1;
    expect_bundle("midrst", 1'b0, 64'h0, 64'h0, 6'd0, 20'h0, 6'd0, 6'd0, 64'h0, 64'h0);
    stackptr = 64'h100;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;

    // After reset: x2 = new stackptr, x1 lost
    step(32'h00010133, 64'h3000, 1'b1, 1'b0, 5'd0, 64'h0);
    expect_bundle("add_rst", 1'b1, 64'h3000, 64'h33, 6'd2, 20'h0, 6'd2, 6'd0, 64'h100, 64'h0);
    step(32'h0020B423, 64'h3004, 1'b1, 1'b0, 5'd0, 64'h0);
    expect_bundle("sd_rst", 1'b1, 64'h3004, 64'h1A3, 6'd0, 20'h00008, 6'd1, 6'd2, 64'h0, 64'h100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
